alu_op_sequencer: RTL

//  Issue side of the ALU operand/opcode interface: accepts register-addressed ALU commands, reads operands from an
//  8x32 register file, drives alu operand1/operand2/aluop, captures alu_out/overflow/zero, writes result back and

---
 rtl/alu_op_sequencer_if.sv | 56 +++++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, host-write, ALU and response bundle for alu_op_sequencer.
// master = host/ALU side, slave = the sequencer itself.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [AW-1:0]     cmd_rd;
  logic [AW-1:0]     cmd_rs1;
  logic [AW-1:0]     cmd_rs2;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;
  logic              host_wr_en;
  logic [AW-1:0]     host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic [3:0]        alu_aluop;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ovf;
  logic              rsp_zero;
  logic              rsp_err;
  logic              ovf_sticky;
  logic              ovf_clear;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    output host_wr_en, host_wr_addr, host_wr_data,
    input  alu_operand1, alu_operand2, alu_aluop,
    output alu_result, alu_ovf, alu_zero,
    input  rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err,
    output rsp_ready,
    input  ovf_sticky,
    output ovf_clear
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output cmd_ready,
    input  host_wr_en, host_wr_addr, host_wr_data,
    output alu_operand1, alu_operand2, alu_aluop,
    input  alu_result, alu_ovf, alu_zero,
    output rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err,
    input  rsp_ready,
    output ovf_sticky,
    input  ovf_clear
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues register-file operands to a combinational ALU, writes the result back and returns a response.
// Optional macro ALU_SAT_EN: ADD/SUB results saturate on signed overflow instead of wrapping.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int         AW     = $clog2(NREGS);
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     rd_q;
  logic              err_q;
  logic              cmd_ready_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [3:0]        aluop_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_ovf_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;
  logic              sticky_q;
  logic [DATA_W-1:0] wb_data;
  logic              wb_zero;
  logic              sticky_set;

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_aluop    = aluop_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_ovf      = rsp_ovf_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.ovf_sticky   = sticky_q;

  always_comb begin
`ifdef ALU_SAT_EN
    wb_data = bus.alu_result;
    wb_zero = bus.alu_zero;
    // Clamp toward the sign of operand1; a saturated value is never zero.
    if (bus.alu_ovf && (aluop_q == OP_ADD || aluop_q == OP_SUB)) begin
      wb_data = op1_q[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      wb_zero = 1'b0;
    end
`else
    wb_data = bus.alu_result;
    wb_zero = bus.alu_zero;
`endif
  end

  assign sticky_set = (state == ISSUE) && !err_q && bus.alu_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      op1_q       <= '0;
      op2_q       <= '0;
      aluop_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      sticky_q <= (sticky_q && !bus.ovf_clear) || sticky_set;
      case (state)
        IDLE: begin
          // Operands read the pre-write register value when a host write lands on the accept edge.
          if (bus.host_wr_en) regs[bus.host_wr_addr] <= bus.host_wr_data;
          if (bus.cmd_valid) begin
            op1_q       <= regs[bus.cmd_rs1];
            op2_q       <= bus.cmd_use_imm ? bus.cmd_imm : regs[bus.cmd_rs2];
            aluop_q     <= bus.cmd_op[3] ? 4'd0 : bus.cmd_op;
            err_q       <= bus.cmd_op[3];
            rd_q        <= bus.cmd_rd;
            cmd_ready_q <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          if (err_q) begin
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_zero_q <= 1'b1;
          end else begin
            rsp_data_q  <= wb_data;
            rsp_ovf_q   <= bus.alu_ovf;
            rsp_zero_q  <= wb_zero;
            regs[rd_q]  <= wb_data;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
